// File: rtl/sram_arbiter_pkg.sv
// Shared types and default sizing for the SRAM arbiter between fetch and data ports.
package sram_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 15;

    localparam int unsigned STALL_W       = 6;
    localparam int unsigned STALL_IF_BIT  = 1;
    localparam int unsigned STALL_MEM_BIT = 3;

    typedef enum logic [1:0] {
        SRAM_IDLE   = 2'd0,
        SRAM_BUSY_D = 2'd1,
        SRAM_BUSY_I = 2'd2
    } sram_state_e;

endpackage

// File: rtl/sram_arbiter.sv
// Serialises fetch and data accesses onto one ack-handshaked SRAM; buffers each port's
// result while the pipeline is frozen and raises per-port stall requests.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall_i,

    input  logic                if_ce_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                stallreq_if_o,

    input  logic                mem_ce_i,
    input  logic                mem_we_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic                stallreq_mem_o,

    output logic                sram_ce_o,
    output logic                sram_we_o,
    output logic [DATA_W/8-1:0] sram_sel_o,
    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic [DATA_W-1:0]   sram_data_o,
    input  logic [DATA_W-1:0]   sram_data_i,
    input  logic                sram_ack_i,
    output logic                bus_err_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    sram_state_e         r_state, w_state_nxt;
    logic                r_ce, w_ce_nxt;
    logic                r_we, w_we_nxt;
    logic [SEL_W-1:0]    r_sel, w_sel_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]   r_if_buf, w_if_buf_nxt;
    logic [DATA_W-1:0]   r_mem_buf, w_mem_buf_nxt;
    logic                r_i_done, w_i_done_nxt;
    logic                r_d_done, w_d_done_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic                r_err, w_err_nxt;

    logic                w_if_pend;
    logic                w_mem_pend;
    logic                w_if_frozen;
    logic                w_mem_frozen;
    logic                w_unused_stall;

    assign w_if_frozen    = stall_i[STALL_IF_BIT];
    assign w_mem_frozen   = stall_i[STALL_MEM_BIT];
    assign w_unused_stall = ^{stall_i[5:4], stall_i[2], stall_i[0]};

    assign w_if_pend  = if_ce_i  & ~r_i_done;
    assign w_mem_pend = mem_ce_i & ~r_d_done;

    assign stallreq_if_o  = w_if_pend;
    assign stallreq_mem_o = w_mem_pend;

    assign if_data_o   = r_if_buf;
    assign mem_data_o  = r_mem_buf;
    assign sram_ce_o   = r_ce;
    assign sram_we_o   = r_we;
    assign sram_sel_o  = r_sel;
    assign sram_addr_o = r_addr;
    assign sram_data_o = r_wdata;
    assign bus_err_o   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SRAM_IDLE;
            r_ce      <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_if_buf  <= '0;
            r_mem_buf <= '0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ce      <= w_ce_nxt;
            r_we      <= w_we_nxt;
            r_sel     <= w_sel_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_if_buf  <= w_if_buf_nxt;
            r_mem_buf <= w_mem_buf_nxt;
            r_i_done  <= w_i_done_nxt;
            r_d_done  <= w_d_done_nxt;
            r_tmo     <= w_tmo_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Done flags survive only while the owning stage is frozen; a completion re-sets them.
    always_comb begin
        w_state_nxt   = r_state;
        w_ce_nxt      = r_ce;
        w_we_nxt      = r_we;
        w_sel_nxt     = r_sel;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_if_buf_nxt  = r_if_buf;
        w_mem_buf_nxt = r_mem_buf;
        w_i_done_nxt  = r_i_done & w_if_frozen;
        w_d_done_nxt  = r_d_done & w_mem_frozen;
        w_tmo_nxt     = r_tmo;
        w_err_nxt     = 1'b0;

        case (r_state)
            SRAM_IDLE: begin
                if (w_mem_pend) begin
                    w_state_nxt = SRAM_BUSY_D;
                    w_ce_nxt    = 1'b1;
                    w_we_nxt    = mem_we_i;
                    w_sel_nxt   = mem_sel_i;
                    w_addr_nxt  = mem_addr_i;
                    w_wdata_nxt = mem_data_i;
                    w_tmo_nxt   = '0;
                end else if (w_if_pend) begin
                    w_state_nxt = SRAM_BUSY_I;
                    w_ce_nxt    = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_sel_nxt   = '1;
                    w_addr_nxt  = if_addr_i;
                    w_wdata_nxt = '0;
                    w_tmo_nxt   = '0;
                end
            end

            SRAM_BUSY_D, SRAM_BUSY_I: begin
                if (sram_ack_i || (r_tmo == TMO_W'(TIMEOUT - 1))) begin
                    w_state_nxt = SRAM_IDLE;
                    w_ce_nxt    = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_err_nxt   = ~sram_ack_i;
                    if (r_state == SRAM_BUSY_D) begin
                        w_d_done_nxt  = 1'b1;
                        w_mem_buf_nxt = (sram_ack_i && !r_we) ? sram_data_i : '0;
                    end else begin
                        w_i_done_nxt  = 1'b1;
                        w_if_buf_nxt  = sram_ack_i ? sram_data_i : '0;
                    end
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end

            default: begin
                w_state_nxt = SRAM_IDLE;
                w_ce_nxt    = 1'b0;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: fetch, arbitration, store, freeze, timeout, reset.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        stallreq_if_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stallreq_mem_o;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_addr_o;
    logic [31:0] sram_data_o;
    logic [31:0] sram_data_i;
    logic        sram_ack_i;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .stallreq_if_o  (stallreq_if_o),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o),
        .stallreq_mem_o (stallreq_mem_o),
        .sram_ce_o      (sram_ce_o),
        .sram_we_o      (sram_we_o),
        .sram_sel_o     (sram_sel_o),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i),
        .sram_ack_i     (sram_ack_i),
        .bus_err_o      (bus_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        stall_i    = '0;
        if_ce_i    = 1'b0;
        if_addr_i  = '0;
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_sel_i  = '0;
        mem_addr_i = '0;
        mem_data_i = '0;
        sram_data_i = '0;
        sram_ack_i = 1'b0;
        tick();
        tick();

        chk("rst_ce",      64'(sram_ce_o),   64'h0);
        chk("rst_we",      64'(sram_we_o),   64'h0);
        chk("rst_addr",    64'(sram_addr_o), 64'h0);
        chk("rst_err",     64'(bus_err_o),   64'h0);
        chk("rst_if_data", 64'(if_data_o),   64'h0);
        chk("rst_mem_data",64'(mem_data_o),  64'h0);

        // Fetch only, ack two cycles after issue
        rst       = 1'b0;
        if_ce_i   = 1'b1;
        if_addr_i = 32'h100;
        tick();
        chk("f_ce1",    64'(sram_ce_o),     64'h1);
        chk("f_addr",   64'(sram_addr_o),   64'h100);
        chk("f_we",     64'(sram_we_o),     64'h0);
        chk("f_stall1", 64'(stallreq_if_o), 64'h1);
        tick();
        chk("f_ce2",    64'(sram_ce_o),     64'h1);
        sram_ack_i  = 1'b1;
        sram_data_i = 32'h24010001;
        tick();
        sram_ack_i  = 1'b0;
        chk("f_ce_off", 64'(sram_ce_o),     64'h0);
        chk("f_data",   64'(if_data_o),     64'h24010001);
        chk("f_stall0", 64'(stallreq_if_o), 64'h0);
        chk("f_we_end", 64'(sram_we_o),     64'h0);
        if_ce_i = 1'b0;
        tick();
        chk("f_idle",   64'(sram_ce_o),     64'h0);

        // Simultaneous load and fetch: data port wins
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h2000;
        if_ce_i    = 1'b1;
        if_addr_i  = 32'h104;
        tick();
        chk("s_ce1",     64'(sram_ce_o),      64'h1);
        chk("s_addr1",   64'(sram_addr_o),    64'h2000);
        chk("s_smem1",   64'(stallreq_mem_o), 64'h1);
        chk("s_sif1",    64'(stallreq_if_o),  64'h1);
        sram_ack_i  = 1'b1;
        sram_data_i = 32'h11112222;
        tick();
        sram_ack_i  = 1'b0;
        chk("s_gap",     64'(sram_ce_o),      64'h0);
        chk("s_mdata",   64'(mem_data_o),     64'h11112222);
        chk("s_smem0",   64'(stallreq_mem_o), 64'h0);
        chk("s_sif_hi",  64'(stallreq_if_o),  64'h1);
        mem_ce_i = 1'b0;
        tick();
        chk("s_ce2",     64'(sram_ce_o),      64'h1);
        chk("s_addr2",   64'(sram_addr_o),    64'h104);
        sram_ack_i  = 1'b1;
        sram_data_i = 32'h33334444;
        tick();
        sram_ack_i  = 1'b0;
        chk("s_idata",   64'(if_data_o),      64'h33334444);
        chk("s_sif0",    64'(stallreq_if_o),  64'h0);
        if_ce_i = 1'b0;
        tick();

        // Store: stores return zero
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_sel_i  = 4'b0011;
        mem_addr_i = 32'h2004;
        mem_data_i = 32'hDEADBEEF;
        tick();
        chk("w_ce",    64'(sram_ce_o),   64'h1);
        chk("w_we",    64'(sram_we_o),   64'h1);
        chk("w_sel",   64'(sram_sel_o),  64'h3);
        chk("w_addr",  64'(sram_addr_o), 64'h2004);
        chk("w_wdata", 64'(sram_data_o), 64'hDEADBEEF);
        mem_data_i = 32'h0;
        tick();
        chk("w_hold",  64'(sram_data_o), 64'hDEADBEEF);
        sram_ack_i  = 1'b1;
        sram_data_i = 32'h5555AAAA;
        tick();
        sram_ack_i  = 1'b0;
        chk("w_ce_off", 64'(sram_ce_o),      64'h0);
        chk("w_we_off", 64'(sram_we_o),      64'h0);
        chk("w_mdata",  64'(mem_data_o),     64'h0);
        chk("w_smem0",  64'(stallreq_mem_o), 64'h0);
        mem_ce_i = 1'b0;
        mem_we_i = 1'b0;
        tick();

        // Freeze: result held while fetch stage stalled
        if_ce_i   = 1'b1;
        if_addr_i = 32'h108;
        stall_i   = 6'b000010;
        tick();
        chk("z_ce",  64'(sram_ce_o), 64'h1);
        sram_ack_i  = 1'b1;
        sram_data_i = 32'h0BADF00D;
        tick();
        sram_ack_i  = 1'b0;
        sram_data_i = 32'hFFFFFFFF;
        chk("z_data", 64'(if_data_o), 64'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("z_no_ce",  64'(sram_ce_o),     64'h0);
            chk("z_held",   64'(if_data_o),     64'h0BADF00D);
            chk("z_sif",    64'(stallreq_if_o), 64'h0);
        end
        stall_i   = 6'b0;
        if_addr_i = 32'h10C;
        tick();
        chk("z_rel_ce",  64'(sram_ce_o),     64'h0);
        chk("z_rel_sif", 64'(stallreq_if_o), 64'h1);
        tick();
        chk("z_next_ce",   64'(sram_ce_o),   64'h1);
        chk("z_next_addr", 64'(sram_addr_o), 64'h10C);
        sram_ack_i  = 1'b1;
        sram_data_i = 32'h01020304;
        tick();
        sram_ack_i  = 1'b0;
        chk("z_next_data", 64'(if_data_o), 64'h01020304);
        if_ce_i = 1'b0;
        tick();

        // Timeout on fetch: 15 busy cycles then abort
        if_ce_i   = 1'b1;
        if_addr_i = 32'h110;
        tick();
        chk("t_ce1", 64'(sram_ce_o), 64'h1);
        for (int i = 2; i <= 15; i++) begin
            tick();
            chk("t_ce_hold", 64'(sram_ce_o), 64'h1);
            chk("t_no_err",  64'(bus_err_o), 64'h0);
        end
        tick();
        chk("t_ce_off", 64'(sram_ce_o),     64'h0);
        chk("t_err",    64'(bus_err_o),     64'h1);
        chk("t_data0",  64'(if_data_o),     64'h0);
        chk("t_sif0",   64'(stallreq_if_o), 64'h0);
        if_ce_i = 1'b0;
        tick();
        chk("t_err_pulse", 64'(bus_err_o), 64'h0);

        // Ack while idle is ignored
        sram_ack_i  = 1'b1;
        sram_data_i = 32'hCAFECAFE;
        tick();
        sram_ack_i  = 1'b0;
        chk("a_if_keep",  64'(if_data_o),  64'h0);
        chk("a_mem_keep", 64'(mem_data_o), 64'h0);

        // Reset in the middle of a store
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h4000;
        mem_data_i = 32'h12345678;
        tick();
        chk("r_ce_pre", 64'(sram_ce_o), 64'h1);
        rst      = 1'b1;
        mem_ce_i = 1'b0;
        mem_we_i = 1'b0;
        tick();
        chk("r_ce",    64'(sram_ce_o),      64'h0);
        chk("r_we",    64'(sram_we_o),      64'h0);
        chk("r_sel",   64'(sram_sel_o),     64'h0);
        chk("r_addr",  64'(sram_addr_o),    64'h0);
        chk("r_wdata", 64'(sram_data_o),    64'h0);
        chk("r_err",   64'(bus_err_o),      64'h0);
        chk("r_smem",  64'(stallreq_mem_o), 64'h0);
        rst        = 1'b0;
        mem_ce_i   = 1'b1;
        mem_addr_i = 32'h4004;
        tick();
        chk("r_new_ce",   64'(sram_ce_o),   64'h1);
        chk("r_new_addr", 64'(sram_addr_o), 64'h4004);
        chk("r_new_we",   64'(sram_we_o),   64'h0);
        sram_ack_i  = 1'b1;
        sram_data_i = 32'h00000077;
        tick();
        sram_ack_i = 1'b0;
        mem_ce_i   = 1'b0;
        chk("r_new_data", 64'(mem_data_o), 64'h77);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
